reg_seq: RTL and testbench
==========================

# reg_seq

Command-driven sequencer for the two-entry, 8-bit register file: R0/R1 with a shared write-data bus, a 1-to-2 write-enable decoder and a 2:1 read mux. It accepts one register-transfer command at a time over a valid/ready handshake. It expands each command into a fixed cycle sequence on REG_SEL/REG_WR/REG_IN and returns read results on a pulsed output. It sits between the control unit and the register-file datapath and is the sole driver of REG_SEL, REG_WR and REG_IN.

## Interface
- DATA_WIDTH, 8, register and data bus width
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  sequencer can accept; command transfers on CMD_VALID & CMD_READY at a rising edge
- CMD_OP  in  2  00 LOAD, 01 MOV, 10 SWAP, 11 READ
- CMD_DST  in  1  destination register index (LOAD, MOV)
- CMD_SRC  in  1  source register index (MOV, READ)
- CMD_IMM  in  DATA_WIDTH  immediate (LOAD)
- REG_OUT  in  DATA_WIDTH  read-mux output; combinationally selected by REG_SEL
- REG_SEL  out  1  drives the decoder SEL and the mux SEL
- REG_WR  out  1  drives the decoder EN
- REG_IN  out  DATA_WIDTH  write data to both registers
- RD_VALID  out  1  one-cycle pulse: RD_DATA valid
- RD_DATA  out  DATA_WIDTH  last READ result; holds until the next READ

## Operation
- States: IDLE, WR_IMM, RD_A, RD_B, WR_A, WR_B.
- IDLE: CMD_READY=1, REG_WR=0, REG_SEL=0, REG_IN=0. On handshake, latch op/dst/src/imm and branch:
  - LOAD -> WR_IMM -> IDLE
  - MOV -> RD_A -> WR_A -> IDLE
  - READ -> RD_A -> IDLE
  - SWAP -> RD_A -> RD_B -> WR_A -> WR_B -> IDLE
- WR_IMM: SEL=dst, WR=1, IN=imm.
- RD_A:
  - MOV/READ: SEL=src. SWAP: SEL=0.
  - Capture REG_OUT into TA at the end of the cycle.
  - READ: also load RD_DATA with REG_OUT and assert RD_VALID in the next cycle.
- RD_B (SWAP only): SEL=1, capture REG_OUT into TB.
- WR_A:
  - MOV: SEL=dst, WR=1, IN=TA.
  - SWAP: SEL=0, WR=1, IN=TB.
- WR_B (SWAP only): SEL=1, WR=1, IN=TA.
- All non-writing states drive WR=0 and IN=0.
- CMD_READY=0 outside IDLE. Commands presented then are held off, not dropped.
- MOV with src==dst performs the write; the value is unchanged.
- Outputs REG_SEL/REG_WR/REG_IN/CMD_READY are decoded combinationally from state and latched fields. RD_VALID/RD_DATA are registered.

## Timing
- Handshake at edge of cycle T. Execution starts in cycle T+1. A register write commits at the end of the cycle in which REG_WR=1.
- LOAD: write in T+1. Next accept possible in T+2.
- MOV: read in T+1, write in T+2. Next accept in T+3.
- READ: read in T+1. RD_VALID=1 and RD_DATA valid in T+2, which is also the earliest next accept.
- SWAP: reads in T+1/T+2, writes in T+3/T+4. Next accept in T+5.
- Back-to-back commands have no bubble beyond the sequences above.
- Reset values: state IDLE, REG_WR=0, REG_SEL=0, REG_IN=0, RD_VALID=0, RD_DATA=0, TA=TB=0. CMD_READY=0 while RST=1.
- REG_WR is gated low whenever RST=1, so no write commits in a reset cycle.
- Reset mid-sequence aborts the command; remaining writes are lost. A SWAP aborted after WR_A leaves R0=R1=old R1.
- Register contents are not reset by this block.

## Configuration
- REG_SEQ_SWAP_EN defined: SWAP is implemented as above, and RD_B/WR_B plus the TB register exist.
- Not defined: opcode 10 is accepted as a NOP (one cycle in WR_IMM with WR forced 0, next accept in T+2). RD_B, WR_B and TB are removed.

## Structure
- Shared package: opcode constants (OP_LOAD, OP_MOV, OP_SWAP, OP_READ), state encoding, DATA_WIDTH default.
- Single module. The register file (two registers, decoder, mux) stays outside and is instantiated by the integrating top alongside reg_seq.

## Test plan
- Reset, then LOAD dst=1 imm=0xD4 -> REG_WR=1, REG_SEL=1, REG_IN=0xD4 in T+1; R1=0xD4 afterwards; CMD_READY low in T+1 only.
- LOAD R0=0x16, then READ src=0 -> RD_VALID pulse one cycle with RD_DATA=0x16; RD_DATA holds 0x16 afterwards.
- R0=0x16, R1=0xD1, MOV src=1 dst=0 -> T+1 SEL=1 WR=0; T+2 SEL=0 WR=1 IN=0xD1; R0=0xD1, R1 unchanged.
- R0=0x16, R1=0xD1, SWAP with REG_SEQ_SWAP_EN -> R0=0xD1, R1=0x16 after T+4; CMD_VALID held high is not accepted before T+5. Without the macro: no write, CMD_READY again in T+2.
- CMD_VALID held high with four queued commands -> each accepted exactly once, in the cycle the previous sequence returns to IDLE.
- RST asserted during a MOV's RD_A cycle -> no REG_WR pulse; destination unchanged; IDLE with all outputs at reset values.

Source files
------------

// File: rtl/reg_seq_pkg.sv
// Shared definitions for the reg_seq register-transfer sequencer:
// opcode encoding, sequencer state encoding and the default data width.
package reg_seq_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOV  = 2'b01,
    OP_SWAP = 2'b10,
    OP_READ = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_IMM,
    ST_RD_A,
    ST_RD_B,
    ST_WR_A,
    ST_WR_B
  } state_t;

endpackage

// File: rtl/reg_seq.sv
// Command-driven sequencer for the external two-entry register file (R0/R1).
// Define REG_SEQ_SWAP_EN to build SWAP; otherwise opcode 10 executes as a one-cycle NOP.
module reg_seq
  import reg_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic                  CMD_DST,
  input  logic                  CMD_SRC,
  input  logic [DATA_WIDTH-1:0] CMD_IMM,
  input  logic [DATA_WIDTH-1:0] REG_OUT,
  output logic                  REG_SEL,
  output logic                  REG_WR,
  output logic [DATA_WIDTH-1:0] REG_IN,
  output logic                  RD_VALID,
  output logic [DATA_WIDTH-1:0] RD_DATA
);

  state_t                state_q, state_nxt;
  op_t                   op_q;
  logic                  dst_q;
  logic                  src_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic [DATA_WIDTH-1:0] ta_q;
`ifdef REG_SEQ_SWAP_EN
  logic [DATA_WIDTH-1:0] tb_q;
`endif
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  sel_c;
  logic                  wr_c;
  logic [DATA_WIDTH-1:0] in_c;
  logic                  ready_c;
  logic                  accept;

  always_comb begin
    state_nxt = state_q;
    sel_c     = 1'b0;
    wr_c      = 1'b0;
    in_c      = '0;
    ready_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (CMD_VALID) begin
          case (op_t'(CMD_OP))
            OP_LOAD: state_nxt = ST_WR_IMM;
            OP_MOV:  state_nxt = ST_RD_A;
            OP_READ: state_nxt = ST_RD_A;
`ifdef REG_SEQ_SWAP_EN
            OP_SWAP: state_nxt = ST_RD_A;
`else
            OP_SWAP: state_nxt = ST_WR_IMM;
`endif
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      // A NOP (SWAP opcode with SWAP disabled) also passes through here with no write.
      ST_WR_IMM: begin
        state_nxt = ST_IDLE;
        if (op_q == OP_LOAD) begin
          sel_c = dst_q;
          wr_c  = 1'b1;
          in_c  = imm_q;
        end
      end
      ST_RD_A: begin
        sel_c = (op_q == OP_SWAP) ? 1'b0 : src_q;
        case (op_q)
          OP_MOV:  state_nxt = ST_WR_A;
`ifdef REG_SEQ_SWAP_EN
          OP_SWAP: state_nxt = ST_RD_B;
`endif
          default: state_nxt = ST_IDLE;
        endcase
      end
`ifdef REG_SEQ_SWAP_EN
      ST_RD_B: begin
        sel_c     = 1'b1;
        state_nxt = ST_WR_A;
      end
`endif
      ST_WR_A: begin
        wr_c      = 1'b1;
        sel_c     = dst_q;
        in_c      = ta_q;
        state_nxt = ST_IDLE;
`ifdef REG_SEQ_SWAP_EN
        if (op_q == OP_SWAP) begin
          sel_c     = 1'b0;
          in_c      = tb_q;
          state_nxt = ST_WR_B;
        end
`endif
      end
`ifdef REG_SEQ_SWAP_EN
      ST_WR_B: begin
        sel_c     = 1'b1;
        wr_c      = 1'b1;
        in_c      = ta_q;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset is synchronous, so the datapath controls are forced idle while RST is high
  // to keep a mid-sequence write from committing on the reset edge.
  assign CMD_READY = ready_c & ~RST;
  assign REG_WR    = wr_c & ~RST;
  assign REG_SEL   = sel_c & ~RST;
  assign REG_IN    = RST ? '0 : in_c;
  assign accept    = CMD_VALID & CMD_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      dst_q      <= 1'b0;
      src_q      <= 1'b0;
      imm_q      <= '0;
      ta_q       <= '0;
`ifdef REG_SEQ_SWAP_EN
      tb_q       <= '0;
`endif
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      rd_valid_q <= 1'b0;
      if (accept) begin
        op_q  <= op_t'(CMD_OP);
        dst_q <= CMD_DST;
        src_q <= CMD_SRC;
        imm_q <= CMD_IMM;
      end
      if (state_q == ST_RD_A) begin
        ta_q <= REG_OUT;
        if (op_q == OP_READ) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= REG_OUT;
        end
      end
`ifdef REG_SEQ_SWAP_EN
      if (state_q == ST_RD_B) begin
        tb_q <= REG_OUT;
      end
`endif
    end
  end

  assign RD_VALID = rd_valid_q;
  assign RD_DATA  = rd_data_q;

endmodule

// File: tb/tb_reg_seq.sv
// Self-checking bench for reg_seq with a behavioural register file and a
// command-level reference model (register contents, busy length, write count).
module tb_reg_seq;
  import reg_seq_pkg::*;

  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RST, CMD_VALID, CMD_READY, CMD_DST, CMD_SRC;
  logic [1:0]    CMD_OP;
  logic [DW-1:0] CMD_IMM, REG_OUT, REG_IN, RD_DATA;
  logic          REG_SEL, REG_WR, RD_VALID;

  logic [DW-1:0] rf  [2];
  logic [DW-1:0] m_r [2];
  logic [DW-1:0] m_rd;
  int            total = 0;
  int            bad   = 0;

  reg_seq #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DST(CMD_DST), .CMD_SRC(CMD_SRC), .CMD_IMM(CMD_IMM),
    .REG_OUT(REG_OUT), .REG_SEL(REG_SEL), .REG_WR(REG_WR), .REG_IN(REG_IN),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA)
  );

  always #5 CLK = ~CLK;

  assign REG_OUT = rf[REG_SEL];
  always @(posedge CLK) if (REG_WR) rf[REG_SEL] <= REG_IN;

  function automatic int exp_busy(input logic [1:0] op);
    if (op == OP_MOV) return 2;
`ifdef REG_SEQ_SWAP_EN
    if (op == OP_SWAP) return 4;
`endif
    return 1;
  endfunction

  function automatic int exp_wrs(input logic [1:0] op);
    if (op == OP_LOAD || op == OP_MOV) return 1;
`ifdef REG_SEQ_SWAP_EN
    if (op == OP_SWAP) return 2;
`endif
    return 0;
  endfunction

  task automatic model(input logic [1:0] op, input logic dst, input logic src,
                       input logic [DW-1:0] imm);
`ifdef REG_SEQ_SWAP_EN
    logic [DW-1:0] t;
`endif
    case (op)
      OP_LOAD: m_r[dst] = imm;
      OP_MOV:  m_r[dst] = m_r[src];
      OP_READ: m_rd = m_r[src];
      default: begin
`ifdef REG_SEQ_SWAP_EN
        t = m_r[0]; m_r[0] = m_r[1]; m_r[1] = t;
`endif
      end
    endcase
  endtask

  task automatic scramble();
    CMD_OP  = 2'($urandom_range(0, 3));
    CMD_DST = 1'($urandom_range(0, 1));
    CMD_SRC = 1'($urandom_range(0, 1));
    CMD_IMM = 8'($urandom_range(0, 255));
  endtask

  // Issues one command and observes it until CMD_READY returns (bounded).
  task automatic run_cmd(input logic [1:0] op, input logic dst, input logic src,
                         input logic [DW-1:0] imm, output int busy, output int wrs,
                         output int rds, output logic [DW-1:0] rd_seen, output bit to);
    int n;
    busy = 0; wrs = 0; rds = 0; rd_seen = '0; to = 1'b1; n = 0;
    CMD_OP = op; CMD_DST = dst; CMD_SRC = src; CMD_IMM = imm; CMD_VALID = 1'b1;
    while (!CMD_READY && n < 20) begin @(negedge CLK); n++; end
    if (!CMD_READY) begin CMD_VALID = 1'b0; return; end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    scramble();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (REG_WR) wrs++;
      if (RD_VALID) begin rds++; rd_seen = RD_DATA; end
      if (CMD_READY) begin to = 1'b0; break; end
      busy++;
    end
    model(op, dst, src, imm);
  endtask

  task automatic test_reset();
    RST = 1'b1; CMD_VALID = 1'b1; scramble();
    @(posedge CLK); @(negedge CLK);
    total++; if (CMD_READY !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", CMD_READY); end
    total++; if ({REG_WR, REG_SEL, REG_IN} !== 10'h0) begin bad++; $display("FAIL rst_ctrl got=%b/%b/%h want=0/0/00", REG_WR, REG_SEL, REG_IN); end
    total++; if ({RD_VALID, RD_DATA} !== 9'h0) begin bad++; $display("FAIL rst_rd got=%b/%h want=0/00", RD_VALID, RD_DATA); end
    @(posedge CLK); #1;
    RST = 1'b0; CMD_VALID = 1'b0;
    @(negedge CLK);
    total++; if ({CMD_READY, REG_WR, REG_SEL, REG_IN} !== {1'b1, 10'h0}) begin bad++; $display("FAIL idle_out got=%b/%b/%b/%h want=1/0/0/00", CMD_READY, REG_WR, REG_SEL, REG_IN); end
    m_r[0] = '0; m_r[1] = '0; m_rd = '0;
  endtask

  task automatic test_load();
    @(posedge CLK); #1;
    CMD_OP = OP_LOAD; CMD_DST = 1'b1; CMD_SRC = 1'b0; CMD_IMM = 8'hD4; CMD_VALID = 1'b1;
    @(negedge CLK);
    total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL load_ready_T got=%b want=1", CMD_READY); end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; scramble();
    @(negedge CLK);
    total++; if ({CMD_READY, REG_WR, REG_SEL, REG_IN} !== {3'b011, 8'hD4}) begin bad++; $display("FAIL load_T1 got=%b/%b/%b/%h want=0/1/1/d4", CMD_READY, REG_WR, REG_SEL, REG_IN); end
    @(negedge CLK);
    total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL load_ready_T2 got=%b want=1", CMD_READY); end
    total++; if (rf[1] !== 8'hD4) begin bad++; $display("FAIL load_r1 got=%h want=d4", rf[1]); end
    model(OP_LOAD, 1'b1, 1'b0, 8'hD4);
  endtask

  task automatic test_read();
    int b, w, r; logic [DW-1:0] rs; bit to;
    run_cmd(OP_LOAD, 1'b0, 1'b0, 8'h16, b, w, r, rs, to);
    total++; if (to || rf[0] !== 8'h16) begin bad++; $display("FAIL read_pre got=%h to=%b want=16", rf[0], to); end
    @(posedge CLK); #1;
    CMD_OP = OP_READ; CMD_DST = 1'b1; CMD_SRC = 1'b0; CMD_IMM = 8'hFF; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; scramble();
    @(negedge CLK);
    total++; if ({CMD_READY, RD_VALID, REG_WR, REG_SEL} !== 4'b0000) begin bad++; $display("FAIL read_T1 got=%b%b%b%b want=0000", CMD_READY, RD_VALID, REG_WR, REG_SEL); end
    @(negedge CLK);
    total++; if ({CMD_READY, RD_VALID, RD_DATA} !== {2'b11, 8'h16}) begin bad++; $display("FAIL read_T2 got=%b/%b/%h want=1/1/16", CMD_READY, RD_VALID, RD_DATA); end
    @(negedge CLK);
    total++; if ({RD_VALID, RD_DATA} !== {1'b0, 8'h16}) begin bad++; $display("FAIL read_hold got=%b/%h want=0/16", RD_VALID, RD_DATA); end
    model(OP_READ, 1'b1, 1'b0, 8'hFF);
  endtask

  task automatic test_mov();
    int b, w, r; logic [DW-1:0] rs; bit to;
    run_cmd(OP_LOAD, 1'b1, 1'b0, 8'hD1, b, w, r, rs, to);
    @(posedge CLK); #1;
    CMD_OP = OP_MOV; CMD_DST = 1'b0; CMD_SRC = 1'b1; CMD_IMM = 8'h00; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; scramble();
    @(negedge CLK);
    total++; if ({CMD_READY, REG_SEL, REG_WR} !== 3'b010) begin bad++; $display("FAIL mov_T1 got=%b%b%b want=010", CMD_READY, REG_SEL, REG_WR); end
    @(negedge CLK);
    total++; if ({CMD_READY, REG_SEL, REG_WR, REG_IN} !== {3'b001, 8'hD1}) begin bad++; $display("FAIL mov_T2 got=%b%b%b/%h want=001/d1", CMD_READY, REG_SEL, REG_WR, REG_IN); end
    @(negedge CLK);
    total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL mov_T3 got=%b want=1", CMD_READY); end
    total++; if ({rf[0], rf[1]} !== 16'hD1D1) begin bad++; $display("FAIL mov_regs got=%h%h want=d1d1", rf[0], rf[1]); end
    model(OP_MOV, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_swap();
    int b, w, r; logic [DW-1:0] rs, e0, e1; bit to;
    run_cmd(OP_LOAD, 1'b0, 1'b0, 8'h16, b, w, r, rs, to);
    run_cmd(OP_LOAD, 1'b1, 1'b0, 8'hD1, b, w, r, rs, to);
    run_cmd(OP_SWAP, 1'b0, 1'b1, 8'h55, b, w, r, rs, to);
`ifdef REG_SEQ_SWAP_EN
    e0 = 8'hD1; e1 = 8'h16;
`else
    e0 = 8'h16; e1 = 8'hD1;
`endif
    total++; if (to || b != exp_busy(OP_SWAP)) begin bad++; $display("FAIL swap_busy got=%0d to=%b want=%0d", b, to, exp_busy(OP_SWAP)); end
    total++; if (w != exp_wrs(OP_SWAP)) begin bad++; $display("FAIL swap_wrs got=%0d want=%0d", w, exp_wrs(OP_SWAP)); end
    total++; if ({rf[0], rf[1]} !== {e0, e1}) begin bad++; $display("FAIL swap_regs got=%h%h want=%h%h", rf[0], rf[1], e0, e1); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    ops [4];
    logic          dst [4], src [4];
    logic [DW-1:0] imm [4];
    int acc [4];
    int i = 0, c = 0;
    bit hs;
    ops[0] = OP_SWAP; ops[1] = OP_LOAD; ops[2] = OP_MOV; ops[3] = OP_READ;
    for (int k = 0; k < 4; k++) begin
      dst[k] = 1'($urandom_range(0, 1)); src[k] = 1'($urandom_range(0, 1));
      imm[k] = 8'($urandom_range(0, 255)); acc[k] = -1;
    end
    @(posedge CLK); #1;
    CMD_OP = ops[0]; CMD_DST = dst[0]; CMD_SRC = src[0]; CMD_IMM = imm[0]; CMD_VALID = 1'b1;
    while (i < 4 && c < 60) begin
      @(negedge CLK);
      hs = CMD_READY;
      if (hs) acc[i] = c;
      @(posedge CLK); #1;
      if (hs) begin
        model(ops[i], dst[i], src[i], imm[i]);
        i++;
        if (i < 4) begin CMD_OP = ops[i]; CMD_DST = dst[i]; CMD_SRC = src[i]; CMD_IMM = imm[i]; end
        else CMD_VALID = 1'b0;
      end
      c++;
    end
    CMD_VALID = 1'b0;
    total++; if (i != 4) begin bad++; $display("FAIL b2b_accepts got=%0d want=4", i); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (acc[k+1] - acc[k] != exp_busy(ops[k]) + 1) begin
        bad++; $display("FAIL b2b_gap%0d got=%0d want=%0d", k, acc[k+1] - acc[k], exp_busy(ops[k]) + 1);
      end
    end
    for (int n = 0; n < 20 && !CMD_READY; n++) @(negedge CLK);
    @(negedge CLK);
    total++; if ({rf[0], rf[1], RD_DATA} !== {m_r[0], m_r[1], m_rd}) begin bad++; $display("FAIL b2b_state got=%h%h/%h want=%h%h/%h", rf[0], rf[1], RD_DATA, m_r[0], m_r[1], m_rd); end
  endtask

  task automatic test_reset_mid();
    int b, w, r; logic [DW-1:0] rs; bit to; int wr_seen = 0;
    run_cmd(OP_LOAD, 1'b0, 1'b0, 8'h16, b, w, r, rs, to);
    run_cmd(OP_LOAD, 1'b1, 1'b0, 8'hD1, b, w, r, rs, to);
    @(posedge CLK); #1;
    CMD_OP = OP_MOV; CMD_DST = 1'b0; CMD_SRC = 1'b1; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; RST = 1'b1;
    @(negedge CLK);
    total++; if ({REG_WR, CMD_READY} !== 2'b00) begin bad++; $display("FAIL rstmov_rd_a got=%b%b want=00", REG_WR, CMD_READY); end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    total++; if ({CMD_READY, REG_WR, REG_SEL, REG_IN, RD_VALID, RD_DATA} !== {1'b1, 19'h0}) begin bad++; $display("FAIL rstmov_idle got=%b/%b/%b/%h/%b/%h want=1/0/0/00/0/00", CMD_READY, REG_WR, REG_SEL, REG_IN, RD_VALID, RD_DATA); end
    for (int k = 0; k < 3; k++) begin @(negedge CLK); if (REG_WR) wr_seen++; end
    total++; if (wr_seen != 0 || rf[0] !== 8'h16) begin bad++; $display("FAIL rstmov_dst got=%h wr=%0d want=16 wr=0", rf[0], wr_seen); end
    m_rd = '0;
    // Reset landing on the LOAD write cycle must suppress the write.
    @(posedge CLK); #1;
    CMD_OP = OP_LOAD; CMD_DST = 1'b1; CMD_IMM = 8'h5A; CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0; RST = 1'b1;
    @(negedge CLK);
    total++; if (REG_WR !== 1'b0) begin bad++; $display("FAIL rstload_wr got=%b want=0", REG_WR); end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    total++; if (rf[1] !== 8'hD1) begin bad++; $display("FAIL rstload_r1 got=%h want=d1", rf[1]); end
  endtask

  task automatic test_random();
    int b, w, r; logic [DW-1:0] rs; bit to;
    logic [1:0] op; logic d, s; logic [DW-1:0] im;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3)); d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1)); im = 8'($urandom_range(0, 255));
      run_cmd(op, d, s, im, b, w, r, rs, to);
      total++; if (to || b != exp_busy(op)) begin bad++; $display("FAIL rnd%0d_busy op=%0d got=%0d to=%b want=%0d", n, op, b, to, exp_busy(op)); end
      total++; if (w != exp_wrs(op)) begin bad++; $display("FAIL rnd%0d_wrs op=%0d got=%0d want=%0d", n, op, w, exp_wrs(op)); end
      total++; if (r != ((op == OP_READ) ? 1 : 0) || (op == OP_READ && rs !== m_rd)) begin bad++; $display("FAIL rnd%0d_rd op=%0d pulses=%0d data=%h want=%h", n, op, r, rs, m_rd); end
      total++; if ({rf[0], rf[1], RD_DATA} !== {m_r[0], m_r[1], m_rd}) begin bad++; $display("FAIL rnd%0d_state op=%0d got=%h%h/%h want=%h%h/%h", n, op, rf[0], rf[1], RD_DATA, m_r[0], m_r[1], m_rd); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_DST = 1'b0; CMD_SRC = 1'b0; CMD_IMM = '0;
    test_reset();
    test_load();
    test_read();
    test_mov();
    test_swap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
